// File: rtl/vreg_pkg.sv
// Shared constants, FSM state type and lane-mask helper for the vector
// register bank (vreg_bank / vreg_lane).
package vreg_pkg;

    localparam int VREG_WIDTH = 32;
    localparam int VREG_LANES = 5;
    localparam int VREG_NREGS = 15;
    localparam int VREG_AW    = $clog2(VREG_NREGS);
    localparam int VREG_VLW   = $clog2(VREG_LANES + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bits i < min(vl, LANES) set; oversize vl saturates to all lanes.
    function automatic logic [VREG_LANES-1:0] lane_mask(
        input logic [VREG_VLW-1:0] vl
    );
        logic [VREG_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < VREG_LANES; i++) begin
            m[i] = (i < int'(vl));
        end
        return m;
    endfunction

endpackage

// File: rtl/vreg_lane.sv
// One lane column of the vector register bank: NREGS x WIDTH storage,
// one write port, two registered read ports with zero-fill and forwarding.
// Ports: clk, reset_n; i_we/i_waddr/i_wdata write; i_re read strobe;
//   i_ren lane inside read vl; i_ra1/i_ra2 sources; i_fwd1/i_fwd2 take
//   i_wdata instead of storage; o_rd1/o_rd2 registered read data.
module vreg_lane
    import vreg_pkg::*;
#(
    parameter int WIDTH = VREG_WIDTH,
    parameter int NREGS = VREG_NREGS,
    parameter int AW    = VREG_AW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic             i_ren,
    input  logic [AW-1:0]    i_ra1,
    input  logic [AW-1:0]    i_ra2,
    input  logic             i_fwd1,
    input  logic             i_fwd2,
    output logic [WIDTH-1:0] o_rd1,
    output logic [WIDTH-1:0] o_rd2
);

    localparam logic [AW:0] LP_NREGS = (AW + 1)'(NREGS);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // Storage is cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range source addresses read as zero.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if ({1'b0, i_ra1} < LP_NREGS) begin
            w_rd1 = r_mem[i_ra1];
        end
        if ({1'b0, i_ra2} < LP_NREGS) begin
            w_rd2 = r_mem[i_ra2];
        end
        if (i_fwd1) begin
            w_rd1 = i_wdata;
        end
        if (i_fwd2) begin
            w_rd2 = i_wdata;
        end
        if (!i_ren) begin
            w_rd1 = '0;
            w_rd2 = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (i_re) begin
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
        end
    end

    assign o_rd1 = r_rd1;
    assign o_rd2 = r_rd2;

endmodule

// File: rtl/vreg_bank.sv
// Vector register file: NREGS regs x LANES lanes x WIDTH bits, handshaked
// masked write, two registered reads, zero sweep after reset and on clr.
// Ports: clk, reset_n (async, low); clr restarts sweep; wr_valid/wr_ready/
//   wr_addr/wr_vl/wr_data write; rd_en/rd_vl/ra1/ra2 read request;
//   rd_valid/rd1_data/rd2_data read result; busy during sweep.
// Option: define VREG_BYPASS_EN to forward a same-cycle accepted write
//   into the read result on the written lanes.
module vreg_bank
    import vreg_pkg::*;
#(
    parameter int WIDTH = VREG_WIDTH,
    parameter int LANES = VREG_LANES,
    parameter int NREGS = VREG_NREGS,
    localparam int AW   = $clog2(NREGS),
    localparam int VLW  = $clog2(LANES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [AW-1:0]          wr_addr,
    input  logic [VLW-1:0]         wr_vl,
    input  logic [LANES*WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [VLW-1:0]         rd_vl,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    output logic                   rd_valid,
    output logic [LANES*WIDTH-1:0] rd1_data,
    output logic [LANES*WIDTH-1:0] rd2_data,
    output logic                   busy
);

    localparam logic [AW:0]   LP_NREGS = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] LP_LAST  = AW'(NREGS - 1);

    state_e           r_state;
    state_e           w_state_nx;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nx;
    logic             r_rd_valid;

    logic             w_sweep;
    logic             w_run;
    logic             w_wr_acc;
    logic             w_rd_fire;
    logic [AW-1:0]    w_laddr;
    logic [LANES-1:0] w_wmask;
    logic [LANES-1:0] w_rmask;
    logic [LANES-1:0] w_fwd1;
    logic [LANES-1:0] w_fwd2;

    logic [LANES*WIDTH-1:0] w_rd1_bus;
    logic [LANES*WIDTH-1:0] w_rd2_bus;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        unique case (r_state)
            ST_INIT: begin
                if (clr) begin
                    w_idx_nx = '0;
                end else if (r_idx == LP_LAST) begin
                    w_state_nx = ST_RUN;
                    w_idx_nx   = '0;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nx = ST_INIT;
                    w_idx_nx   = '0;
                end
            end
            default: begin
                w_state_nx = ST_INIT;
                w_idx_nx   = '0;
            end
        endcase
    end

    assign w_sweep = (r_state == ST_INIT);
    assign w_run   = (r_state == ST_RUN);

    // clr beats a same-cycle write; out-of-range writes are dropped.
    assign w_wr_acc = w_run && wr_valid && !clr
                      && ({1'b0, wr_addr} < LP_NREGS);

    assign w_wmask   = w_wr_acc ? lane_mask(wr_vl) : '0;
    assign w_rmask   = lane_mask(rd_vl);
    assign w_rd_fire = w_run && rd_en;
    assign w_laddr   = w_sweep ? r_idx : wr_addr;

`ifdef VREG_BYPASS_EN
    assign w_fwd1 = w_wmask & {LANES{wr_addr == ra1}};
    assign w_fwd2 = w_wmask & {LANES{wr_addr == ra2}};
`else
    assign w_fwd1 = '0;
    assign w_fwd2 = '0;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vreg_lane #(
            .WIDTH (WIDTH),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .i_we    (w_sweep | w_wmask[l]),
            .i_waddr (w_laddr),
            .i_wdata (w_sweep ? '0 : wr_data[l*WIDTH +: WIDTH]),
            .i_re    (w_rd_fire),
            .i_ren   (w_rmask[l]),
            .i_ra1   (ra1),
            .i_ra2   (ra2),
            .i_fwd1  (w_fwd1[l]),
            .i_fwd2  (w_fwd2[l]),
            .o_rd1   (w_rd1_bus[l*WIDTH +: WIDTH]),
            .o_rd2   (w_rd2_bus[l*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd1_data = w_rd1_bus;
    assign rd2_data = w_rd2_bus;
    assign busy     = w_sweep;
    assign wr_ready = w_run;

endmodule

// File: tb/tb_vreg_bank.sv
// Directed self-checking bench for vreg_bank (default 32x5x15 geometry).
// Expected vectors are hand-computed constants.
module tb_vreg_bank;

    logic         clk;
    logic         reset_n;
    logic         clr;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [2:0]   wr_vl;
    logic [159:0] wr_data;
    logic         rd_en;
    logic [2:0]   rd_vl;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic         rd_valid;
    logic [159:0] rd1_data;
    logic [159:0] rd2_data;
    logic         busy;

    int n_pass;
    int n_total;

    localparam logic [159:0] Z   = '0;
    localparam logic [159:0] F5  = {5{32'hFFFF_FFFF}};
    localparam logic [159:0] V2  = {5{32'h2}};
    localparam logic [159:0] V5  = {5{32'h5}};
    localparam logic [159:0] V9  = {5{32'h9}};
    localparam logic [159:0] VA  = {5{32'hA}};
    localparam logic [159:0] V55 = {5{32'h55}};
    localparam logic [159:0] V77 = {5{32'h77}};
    localparam logic [159:0] S76543 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3};
    localparam logic [159:0] S765FF = {32'd7, 32'd6, 32'd5,
                                       32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [159:0] S005FF = {32'd0, 32'd0, 32'd5,
                                       32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [159:0] S765FA = {32'd7, 32'd6, 32'd5,
                                       32'hFFFF_FFFF, 32'hA};
    localparam logic [159:0] S12345 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};

    vreg_bank u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_vl    (wr_vl),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_vl    (rd_vl),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd_valid (rd_valid),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [2:0] vl,
                      input logic [159:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_vl    = vl;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [2:0] vl);
        rd_en = 1'b1;
        ra1   = a1;
        ra2   = a2;
        rd_vl = vl;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wait_sweep(input string tag);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk(tag, 160'(cnt), 160'(15));
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset_n  = 1'b0;
        clr      = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_vl    = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_vl    = '0;
        ra1      = '0;
        ra2      = '0;

        // Reset state
        repeat (3) step();
        chk("rst_flags", 160'({busy, wr_ready, rd_valid}), 160'(3'b100));
        chk("rst_rd1", rd1_data, Z);
        chk("rst_rd2", rd2_data, Z);

        // Sweep: 15 busy cycles, reads ignored meanwhile
        reset_n = 1'b1;
        rd_en   = 1'b1;
        rd_vl   = 3'd5;
        for (int k = 0; k < 15; k++) begin
            chk("init_flags", 160'({busy, wr_ready, rd_valid}), 160'(3'b100));
            step();
        end
        chk("run_flags", 160'({busy, wr_ready, rd_valid}), 160'(3'b010));
        rd_en = 1'b0;

        for (int r = 1; r < 15; r++) begin
            rd(4'(r), 4'(15 - r), 3'd5);
            chk("zero_rd", {rd1_data[79:0], rd2_data[79:0]},
                {Z[79:0], Z[79:0]});
            chk("zero_hi", {rd1_data[159:80], rd2_data[159:80]}, Z);
        end

        // Full write then read, latency 1
        step();
        wr(4'd2, 3'd5, S76543);
        chk("rdv_idle", 160'(rd_valid), 160'(0));
        rd(4'd2, 4'd0, 3'd5);
        chk("rdv_lat", 160'(rd_valid), 160'(1));
        chk("r2_full", rd1_data, S76543);

        // Partial write keeps upper lanes; short read zero-fills
        wr(4'd2, 3'd2, F5);
        rd(4'd2, 4'd2, 3'd5);
        chk("r2_part_1", rd1_data, S765FF);
        chk("r2_part_2", rd2_data, S765FF);
        rd(4'd2, 4'd2, 3'd3);
        chk("r2_vl3", rd1_data, S005FF);
        step();
        chk("rdv_drop", 160'(rd_valid), 160'(0));
        chk("rd_hold", rd1_data, S005FF);

        // Same-cycle write and read
        wr_valid = 1'b1;
        wr_addr  = 4'd1;
        wr_vl    = 3'd5;
        wr_data  = V2;
        rd_en    = 1'b1;
        ra1      = 4'd1;
        ra2      = 4'd0;
        rd_vl    = 3'd5;
        step();
`ifdef VREG_BYPASS_EN
        chk("same_cyc", rd1_data, V2);
`else
        chk("same_cyc", rd1_data, Z);
`endif
        wr_addr = 4'd2;
        wr_vl   = 3'd1;
        wr_data = VA;
        ra1     = 4'd1;
        ra2     = 4'd2;
        step();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        chk("r1_after", rd1_data, V2);
`ifdef VREG_BYPASS_EN
        chk("same_part", rd2_data, S765FA);
`else
        chk("same_part", rd2_data, S765FF);
`endif
        rd(4'd2, 4'd1, 3'd5);
        chk("r2_after", rd1_data, S765FA);

        // clr with write pending: write dropped, sweep, clr restarts sweep
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_vl    = 3'd5;
        wr_data  = V9;
        step();
        clr      = 1'b0;
        wr_valid = 1'b0;
        chk("clr_flags", 160'({busy, wr_ready}), 160'(2'b10));
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        wait_sweep("clr_sweep");
        rd(4'd3, 4'd1, 3'd5);
        chk("clr_r3", rd1_data, Z);
        chk("clr_r1", rd2_data, Z);
        rd(4'd2, 4'd0, 3'd5);
        chk("clr_r2", rd1_data, Z);

        // Reset mid-sweep and mid-write
        wr(4'd4, 3'd5, V5);
        rd(4'd4, 4'd4, 3'd5);
        chk("r4_pre", rd1_data, V5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        wr_valid = 1'b1;
        wr_addr  = 4'd5;
        wr_vl    = 3'd5;
        wr_data  = V77;
        reset_n  = 1'b0;
        #1;
        chk("arst_flags", 160'({busy, wr_ready, rd_valid}), 160'(3'b100));
        chk("arst_rd1", rd1_data, Z);
        chk("arst_rd2", rd2_data, Z);
        repeat (2) step();
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        wait_sweep("rst_sweep");
        rd(4'd4, 4'd5, 3'd5);
        chk("rst_r4", rd1_data, Z);
        chk("rst_r5", rd2_data, Z);

        // vl clamp, vl=0, out-of-range address
        wr(4'd6, 3'd7, S12345);
        rd(4'd6, 4'd6, 3'd7);
        chk("clamp_w", rd1_data, S12345);
        chk("clamp_r", rd2_data, S12345);
        wr(4'd6, 3'd0, F5);
        rd(4'd6, 4'd0, 3'd5);
        chk("vl0", rd1_data, S12345);
        wr(4'd15, 3'd5, V55);
        rd(4'd15, 4'd14, 3'd5);
        chk("oor_rd", rd1_data, Z);
        chk("oor_r14", rd2_data, Z);
        rd(4'd0, 4'd6, 3'd5);
        chk("oor_r0", rd1_data, Z);
        chk("oor_r6", rd2_data, S12345);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
